// File: rtl/mem_access_if.sv
// mem_access_if: request/response handshake and RAM port bundle for mem_access_ctrl.
interface mem_access_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              wr_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, wr_done, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, wr_done, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time load/store sequencer driving a single-port synchronous RAM
// for WAIT_CYCLES+1 cycles per access, with a held read response and a write-done pulse.
module mem_access_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input logic           clk_i,
    input logic           rst_ni,
    mem_access_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              wr_done_q, wr_done_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            wr_done_q   <= wr_done_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        wr_done_d   = 1'b0;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                // ready rises on the first clock after reset, so accept needs the registered ready
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.req_we;
                    mem_addr_d  = bus.req_addr;
                    mem_wdata_d = bus.req_wdata;
                    cnt_d       = WAIT_LD;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    mem_en_d = 1'b0;
                    if (mem_we_q) begin
                        mem_we_d    = 1'b0;
                        wr_done_d   = 1'b1;
                        req_ready_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        rsp_rdata_d = bus.mem_rdata;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.wr_done   = wr_done_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Load/store sequencer between the CPU datapath and a single-port synchronous data RAM.
- Accepts one read or write request at a time over a valid/ready handshake.
- Drives the RAM for a programmable number of wait states.
- Returns read data over a valid/ready response channel, whose output feeds the 16-bit destination register's D input.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data width in bits.
- WAIT_CYCLES, 2, extra RAM access cycles beyond the first; legal range 0..15.

Ports:
- CLK  input  1  rising-edge clock
- RES  input  1  asynchronous reset, active-low
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  request address
- req_wdata  input  DATA_W  write data
- rsp_valid  output  1  read data available
- rsp_ready  input  1  consumer takes read data
- rsp_rdata  output  DATA_W  read data
- wr_done  output  1  one-cycle pulse when a write completes
- mem_en  output  1  RAM enable
- mem_we  output  1  RAM write strobe
- mem_addr  output  ADDR_W  RAM address
- mem_wdata  output  DATA_W  RAM write data
- mem_rdata  input  DATA_W  RAM read data, valid on the final access cycle

Behaviour:
- Reset (RES low, asynchronous):
  - State = IDLE.
  - req_ready, rsp_valid, wr_done, mem_en and mem_we = 0.
  - mem_addr, mem_wdata and rsp_rdata = 0.
  - Wait counter = 0.
  - Any in-flight access is dropped with no response and no wr_done.
- req_ready is registered:
  - Goes to 1 at the first rising edge with RES high.
  - Is 1 in IDLE only.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Accept occurs at an edge where req_valid = 1 and req_ready = 1.
  - On accept: latch req_we, req_addr and req_wdata into mem_we/mem_addr/mem_wdata; load counter with WAIT_CYCLES; clear req_ready; go to ACCESS.
- ACCESS:
  - mem_en = 1 and mem_addr is stable for exactly WAIT_CYCLES+1 cycles.
  - mem_we = latched we for the whole ACCESS period.
  - The counter decrements each edge while it is nonzero.
  - Edge with counter = 0, read: capture mem_rdata into rsp_rdata, set rsp_valid, clear mem_en, go to RESP.
  - Edge with counter = 0, write: clear mem_en/mem_we, pulse wr_done for one cycle, set req_ready, go to IDLE.
- RESP:
  - rsp_valid and rsp_rdata are held stable until an edge where rsp_ready = 1.
  - At that edge: clear rsp_valid, set req_ready, go to IDLE.
  - rsp_rdata keeps its last value after the handshake.
- Latency:
  - Read: rsp_valid rises WAIT_CYCLES+1 edges after the accept edge.
  - Write: wr_done is high in the cycle after the last ACCESS cycle.
- Throughput:
  - No new request is accepted in ACCESS or RESP.
  - Minimum spacing between accepts is WAIT_CYCLES+2 cycles for writes.
  - For reads, minimum spacing is WAIT_CYCLES+2 cycles plus the response stall.
- Boundaries and simultaneous events:
  - req_valid is ignored when req_ready = 0; request inputs may change freely outside IDLE.
  - WAIT_CYCLES = 0 gives a single-cycle ACCESS.
  - rsp_ready already high at entry to RESP gives exactly one cycle of rsp_valid.
  - Address 0xFFFF is passed unmodified; there is no address wrap or arithmetic.
  - rsp_ready while in IDLE or ACCESS has no effect.
  - RES asserted during ACCESS clears mem_en immediately (asynchronously).

Test Plan:
- Reset release, WAIT_CYCLES = 2: req_ready = 0 during reset, 1 one edge after RES rises; all mem_* outputs = 0.
- Read addr 0x0040, RAM returns 0xBEEF, rsp_ready held 1:
  - mem_en high 3 cycles with mem_addr = 0x0040 and mem_we = 0.
  - rsp_valid high 1 cycle with rsp_rdata = 0xBEEF, 3 edges after accept.
- Write addr 0xFFFF data 0x1234:
  - mem_en = mem_we = 1 for 3 cycles, mem_wdata = 0x1234.
  - wr_done pulses once, then req_ready = 1.
- Read with rsp_ready held 0 for 5 cycles:
  - rsp_valid and rsp_rdata stay stable throughout; req_ready stays 0.
  - A competing req_valid is not accepted until 1 edge after rsp_ready rises.
- RES pulsed low in the 2nd ACCESS cycle of a read: mem_en drops immediately; no rsp_valid; next request behaves normally.
- WAIT_CYCLES = 0 build, back-to-back write then read with req_valid held high:
  - Each access has a single mem_en cycle.
  - Accepts are 2 cycles apart.
